// File: rtl/scalar_wb_arbiter_pkg.sv
// Shared processor definitions for the scalar writeback path.
//   REG_IDX_W     : scalar register index width
//   WB_ALU/LOAD/VRED : writeback requester indices
//   GNT_ID_W      : width of the granted-requester id
//   WB_CNT_W      : width of the writeback counter
package scalar_wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int GNT_ID_W  = 2;
    localparam int WB_CNT_W  = 16;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_VRED = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [GNT_ID_W-1:0]  gnt_id_t;

endpackage

// File: rtl/scalar_wb_arbiter_if.sv
// Writeback bus between the requesters and the scalar register file.
//   req_valid/req_rd/req_wd : per-requester write requests (requester side drives)
//   req_ready               : one-hot (or zero) acceptance
//   WES/RD/WD/gnt_id        : registered register-file write port
// master = requester/register-file side, slave = arbiter.
interface scalar_wb_arbiter_if
    import scalar_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 3
);
    logic [NREQ-1:0]                 req_valid;
    logic [NREQ-1:0][REG_IDX_W-1:0]  req_rd;
    logic [NREQ-1:0][WIDTH-1:0]      req_wd;
    logic [NREQ-1:0]                 req_ready;

    logic                            WES;
    reg_idx_t                        RD;
    logic [WIDTH-1:0]                WD;
    gnt_id_t                         gnt_id;

    modport master (
        output req_valid, req_rd, req_wd,
        input  req_ready, WES, RD, WD, gnt_id
    );

    modport slave (
        input  req_valid, req_rd, req_wd,
        output req_ready, WES, RD, WD, gnt_id
    );

endinterface

// File: rtl/scalar_wb_arbiter_rr_select.sv
// rr_select: combinational round-robin pick.
//   req_i  : request vector
//   last_i : index of the previous grant
//   gnt_o  : one-hot grant (zero when no request)
// Search starts at last_i+1 and wraps, so the previous winner is lowest priority.
module rr_select #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o
);

    always_comb begin : sel
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_i) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: round-robin arbiter merging NREQ writeback requesters
// onto the single scalar register-file write port.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : squashes this cycle's grant (WES=0 next cycle)
//   bus       : requester handshake + registered WES/RD/WD/gnt_id
//   wb_count  : saturating count of writebacks put on the port
// NREQ legal range is 2..4 (gnt_id is 2 bits).
module scalar_wb_arbiter
    import scalar_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    scalar_wb_arbiter_if.slave     bus,
    output logic [WB_CNT_W-1:0]    wb_count
);

    logic [NREQ-1:0]      sel;
    logic [NREQ-1:0]      ready;
    logic                 xfer;
    gnt_id_t              gnt_idx;
    reg_idx_t             rd_mux;
    logic [WIDTH-1:0]     wd_mux;

    logic                 wes_q,  wes_d;
    reg_idx_t             rd_q,   rd_d;
    logic [WIDTH-1:0]     wd_q,   wd_d;
    gnt_id_t              gid_q,  gid_d;
    gnt_id_t              last_q, last_d;
    logic [WB_CNT_W-1:0]  cnt_q,  cnt_d;

    rr_select #(.N(NREQ), .IDX_W(GNT_ID_W)) u_rr (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .gnt_o  (sel)
    );

    // sel is already a subset of req_valid, so any ready bit is a transfer.
    assign ready         = (rst || flush) ? '0 : sel;
    assign xfer          = |ready;
    assign bus.req_ready = ready;

    always_comb begin
        gnt_idx = '0;
        rd_mux  = '0;
        wd_mux  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready[i]) begin
                gnt_idx = GNT_ID_W'(i);
                rd_mux  = bus.req_rd[i];
                wd_mux  = bus.req_wd[i];
            end
        end
    end

    // wb_count moves together with WES, so it already includes the write
    // currently on the port.
    always_comb begin
        wes_d  = xfer;
        rd_d   = xfer ? rd_mux  : rd_q;
        wd_d   = xfer ? wd_mux  : wd_q;
        gid_d  = xfer ? gnt_idx : gid_q;
        last_d = xfer ? gnt_idx : last_q;
        cnt_d  = cnt_q;
        if (wes_d && (cnt_q != {WB_CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // last_q resets to NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wes_q  <= 1'b0;
            rd_q   <= '0;
            wd_q   <= '0;
            gid_q  <= '0;
            last_q <= GNT_ID_W'(NREQ - 1);
            cnt_q  <= '0;
        end else begin
            wes_q  <= wes_d;
            rd_q   <= rd_d;
            wd_q   <= wd_d;
            gid_q  <= gid_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.WES    = wes_q;
    assign bus.RD     = rd_q;
    assign bus.WD     = wd_q;
    assign bus.gnt_id = gid_q;
    assign wb_count   = cnt_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
module tb_scalar_wb_arbiter;
    import scalar_wb_arbiter_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREQ  = 3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] wb_count;

    scalar_wb_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

    scalar_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic wes, input logic [4:0] rd,
                           input logic [15:0] wd, input logic [1:0] gid, input logic [15:0] cnt);
        chk({tag, ".WES"},      32'(bus.WES),    32'(wes));
        chk({tag, ".RD"},       32'(bus.RD),     32'(rd));
        chk({tag, ".WD"},       32'(bus.WD),     32'(wd));
        chk({tag, ".gnt_id"},   32'(bus.gnt_id), 32'(gid));
        chk({tag, ".wb_count"}, 32'(wb_count),   32'(cnt));
    endtask

    // Reference: spec-level round robin, first pending index after last (mod NREQ).
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit                     is_rst;
        logic [2:0]             v;
        logic                   fl;
        logic [2:0][4:0]        rd;
        logic [2:0][15:0]       wd;
        logic [2:0]             rdy;
        logic                   wes;
        logic [4:0]             erd;
        logic [15:0]            ewd;
        logic [1:0]             gid;
        logic [15:0]            cnt;
    } vec_t;

    function automatic vec_t mk(bit r, logic [2:0] v, logic fl,
                                logic [4:0] rd0, logic [15:0] wd0,
                                logic [4:0] rd1, logic [15:0] wd1,
                                logic [4:0] rd2, logic [15:0] wd2,
                                logic [2:0] rdy, logic wes, logic [4:0] erd,
                                logic [15:0] ewd, logic [1:0] gid, logic [15:0] cnt);
        vec_t t;
        t.is_rst = r; t.v = v; t.fl = fl;
        t.rd[0] = rd0; t.rd[1] = rd1; t.rd[2] = rd2;
        t.wd[0] = wd0; t.wd[1] = wd1; t.wd[2] = wd2;
        t.rdy = rdy; t.wes = wes; t.erd = erd; t.ewd = ewd; t.gid = gid; t.cnt = cnt;
        return t;
    endfunction

    vec_t tbl[19];

    initial begin
        logic [NREQ-1:0]            pv;
        logic [NREQ-1:0][4:0]       prd;
        logic [NREQ-1:0][15:0]      pwd;
        int                         m_last;
        int                         m_cnt;
        logic                       m_wes;
        logic [4:0]                 m_rd;
        logic [15:0]                m_wd;
        logic [1:0]                 m_gid;

        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_wd    = '0;

        //          rst v      fl rd0 wd0      rd1 wd1    rd2 wd2    rdy     wes rd wd       gid cnt
        tbl[0]  = mk(1, 3'b000, 0, 0, 16'h0,    0, 16'h0,  0, 16'h0,  3'b000, 0, 0, 16'h0,    0, 0);
        tbl[1]  = mk(0, 3'b001, 0, 4, 16'h00AA, 0, 16'h0,  0, 16'h0,  3'b001, 1, 4, 16'h00AA, 0, 1);
        tbl[2]  = mk(0, 3'b000, 0, 0, 16'h0,    0, 16'h0,  0, 16'h0,  3'b000, 0, 4, 16'h00AA, 0, 1);
        tbl[3]  = mk(1, 3'b000, 0, 0, 16'h0,    0, 16'h0,  0, 16'h0,  3'b000, 0, 0, 16'h0,    0, 0);
        tbl[4]  = mk(0, 3'b011, 1, 5, 16'h0055, 6, 16'h66, 0, 16'h0,  3'b000, 0, 0, 16'h0,    0, 0);
        tbl[5]  = mk(0, 3'b011, 0, 5, 16'h0055, 6, 16'h66, 0, 16'h0,  3'b001, 1, 5, 16'h0055, 0, 1);
        tbl[6]  = mk(0, 3'b010, 0, 5, 16'h0055, 6, 16'h66, 0, 16'h0,  3'b010, 1, 6, 16'h0066, 1, 2);
        tbl[7]  = mk(1, 3'b000, 0, 0, 16'h0,    0, 16'h0,  0, 16'h0,  3'b000, 0, 0, 16'h0,    0, 0);
        tbl[8]  = mk(0, 3'b111, 0, 1, 16'h11,   2, 16'h22, 3, 16'h33, 3'b001, 1, 1, 16'h11,   0, 1);
        tbl[9]  = mk(0, 3'b111, 0, 1, 16'h11,   2, 16'h22, 3, 16'h33, 3'b010, 1, 2, 16'h22,   1, 2);
        tbl[10] = mk(0, 3'b111, 0, 1, 16'h11,   2, 16'h22, 3, 16'h33, 3'b100, 1, 3, 16'h33,   2, 3);
        tbl[11] = mk(0, 3'b111, 0, 1, 16'h11,   2, 16'h22, 3, 16'h33, 3'b001, 1, 1, 16'h11,   0, 4);
        tbl[12] = mk(0, 3'b111, 0, 1, 16'h11,   2, 16'h22, 3, 16'h33, 3'b010, 1, 2, 16'h22,   1, 5);
        tbl[13] = mk(0, 3'b111, 0, 1, 16'h11,   2, 16'h22, 3, 16'h33, 3'b100, 1, 3, 16'h33,   2, 6);
        tbl[14] = mk(0, 3'b000, 0, 0, 16'h0,    0, 16'h0,  0, 16'h0,  3'b000, 0, 3, 16'h33,   2, 6);
        tbl[15] = mk(0, 3'b101, 0, 7, 16'h1,    0, 16'h0,  7, 16'h2,  3'b001, 1, 7, 16'h1,    0, 7);
        tbl[16] = mk(0, 3'b100, 0, 7, 16'h1,    0, 16'h0,  7, 16'h2,  3'b100, 1, 7, 16'h2,    2, 8);
        tbl[17] = mk(0, 3'b001, 0, 0, 16'hBEEF, 0, 16'h0,  0, 16'h0,  3'b001, 1, 0, 16'hBEEF, 0, 9);
        tbl[18] = mk(0, 3'b000, 0, 0, 16'h0,    0, 16'h0,  0, 16'h0,  3'b000, 0, 0, 16'hBEEF, 0, 9);

        // Power-on reset, checked while asserted.
        #1;
        chk("por.ready", 32'(bus.req_ready), 32'h0);
        chk_out("por", 1'b0, 5'd0, 16'h0, 2'd0, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (tbl[i].is_rst) begin
                rst = 1'b1;
                bus.req_valid = '0;
                flush = 1'b0;
                #1;
                chk({tag, ".ready"}, 32'(bus.req_ready), 32'h0);
                chk_out(tag, 1'b0, 5'd0, 16'h0, 2'd0, 16'h0);
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                bus.req_valid = tbl[i].v;
                bus.req_rd    = tbl[i].rd;
                bus.req_wd    = tbl[i].wd;
                flush         = tbl[i].fl;
                #1;
                chk({tag, ".ready"}, 32'(bus.req_ready), 32'(tbl[i].rdy));
                @(posedge clk);
                #1;
                chk_out(tag, tbl[i].wes, tbl[i].erd, tbl[i].ewd, tbl[i].gid, tbl[i].cnt);
            end
        end
        bus.req_valid = '0;
        flush = 1'b0;

        // Asynchronous reset in the middle of a WES cycle.
        do_reset();
        bus.req_valid = 3'b001;
        bus.req_rd[0] = 5'd9;
        bus.req_wd[0] = 16'h1234;
        @(posedge clk);
        #1;
        chk("arst.pre_wes", 32'(bus.WES), 32'h1);
        chk("arst.pre_cnt", 32'(wb_count), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.wes", 32'(bus.WES), 32'h0);
        chk("arst.cnt", 32'(wb_count), 32'h0);
        chk("arst.rd", 32'(bus.RD), 32'h0);
        chk("arst.ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = '0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.no_ghost_wes", 32'(bus.WES), 32'h0);
        bus.req_valid = 3'b011;
        bus.req_rd[1] = 5'd10;
        bus.req_wd[1] = 16'h5678;
        #1;
        chk("arst.first_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("arst.first_gid", 32'(bus.gnt_id), 32'h0);
        chk("arst.first_wes", 32'(bus.WES), 32'h1);

        // Randomized traffic against the reference model.
        do_reset();
        pv = '0; prd = '0; pwd = '0;
        m_last = NREQ - 1; m_cnt = 0;
        m_wes = 1'b0; m_rd = '0; m_wd = '0; m_gid = '0;
        for (int c = 0; c < 600; c++) begin
            int g;
            logic [NREQ-1:0] exp_rdy;
            for (int r = 0; r < NREQ; r++) begin
                if (!pv[r] && $urandom_range(0, 2) == 0) begin
                    pv[r]  = 1'b1;
                    prd[r] = 5'($urandom);
                    pwd[r] = 16'($urandom);
                end
            end
            flush = ($urandom_range(0, 7) == 0);
            bus.req_valid = pv;
            bus.req_rd    = prd;
            bus.req_wd    = pwd;
            g = flush ? -1 : rr_pick(pv, m_last);
            exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
            #1;
            chk($sformatf("rnd%0d.ready", c), 32'(bus.req_ready), 32'(exp_rdy));
            @(posedge clk);
            #1;
            if (g >= 0) begin
                m_wes  = 1'b1;
                m_rd   = prd[g];
                m_wd   = pwd[g];
                m_gid  = 2'(g);
                m_last = g;
                pv[g]  = 1'b0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_wes = 1'b0;
            end
            chk_out($sformatf("rnd%0d", c), m_wes, m_rd, m_wd, m_gid, 16'(m_cnt));
        end
        flush = 1'b0;

        // Saturation of wb_count under continuous traffic.
        do_reset();
        bus.req_valid = 3'b111;
        for (int c = 1; c <= 65540; c++) begin
            @(posedge clk);
            #1;
            if (c == 65534) chk("sat.fffe", 32'(wb_count), 32'hFFFE);
            if (c == 65535) chk("sat.ffff", 32'(wb_count), 32'hFFFF);
            if (c == 65540) begin
                chk("sat.hold", 32'(wb_count), 32'hFFFF);
                chk("sat.wes", 32'(bus.WES), 32'h1);
            end
        end
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        chk("sat.idle_cnt", 32'(wb_count), 32'hFFFF);
        chk("sat.idle_wes", 32'(bus.WES), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
